demux_1x2_reg: RTL and testbench

//  Registered 1-to-2 demultiplexer with valid/ready handshake: routes a WIDTH-bit word on D
//  to output channel 0 or 1 per SEL and holds it until that consumer accepts it.

---
 rtl/demux_1x2_reg_pkg.sv | 15 +
 rtl/demux_1x2_reg_slot.sv | 57 +++++
 rtl/demux_1x2_reg.sv | 70 +++++++
 tb/tb_demux_1x2_reg.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/demux_1x2_reg_pkg.sv
// Shared definitions for the registered 1-to-2 demultiplexer.
// Slot state encoding and counter width used by demux_slot and demux_1x2_reg.
// Optional feature macro: DEMUX_CNT_EN (per-channel output transfer counters).
package demux_1x2_reg_pkg;

    // Per-channel holding slot state: empty or holding one word
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } slot_state_e;

    // Width of the per-channel completed-transfer counters
    localparam int CNT_W = 8;

endpackage : demux_1x2_reg_pkg

// File: rtl/demux_1x2_reg_slot.sv
// demux_slot: one output channel of the 1-to-2 demultiplexer.
// Holds one word, tracks EMPTY/FULL, and optionally counts completed drains.
// Optional feature macro: DEMUX_CNT_EN (counter present when defined, else cnt tied to 0).
module demux_slot
    import demux_1x2_reg_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic             drain,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic [CNT_W-1:0] cnt
);

    slot_state_e      state_reg;
    logic [WIDTH-1:0] data_reg;

    // Slot FSM and data register: a load wins over a drain so that a
    // simultaneous drain+load replaces the word in place and stays full
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_EMPTY;
            data_reg  <= '0;
        end else if (load) begin
            state_reg <= ST_FULL;
            data_reg  <= din;
        end else if (drain) begin
            // Data is left as-is; only the slot is released
            state_reg <= ST_EMPTY;
        end
    end

    assign data  = data_reg;
    assign valid = (state_reg == ST_FULL);

`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0] cnt_reg;

    // Completed output transfers on this channel; wraps naturally at 2**CNT_W
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg <= '0;
        end else if (drain) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign cnt = cnt_reg;
`else
    assign cnt = '0;
`endif

endmodule : demux_slot

// File: rtl/demux_1x2_reg.sv
// demux_1x2_reg: registered 1-to-2 demultiplexer with valid/ready handshake.
// Routes D to channel SEL and holds it in that channel's slot until consumed;
// the two channels drain independently. Top level holds only SEL decode and
// IN_READY; each channel is a demux_slot instance.
// Optional feature macro: DEMUX_CNT_EN (CNT0/CNT1 count output transfers).
module demux_1x2_reg
    import demux_1x2_reg_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] D,
    input  logic             SEL,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] OUT0,
    output logic             OUT0_VALID,
    input  logic             OUT0_READY,
    output logic [WIDTH-1:0] OUT1,
    output logic             OUT1_VALID,
    input  logic             OUT1_READY,
    output logic [CNT_W-1:0] CNT0,
    output logic [CNT_W-1:0] CNT1
);

    logic [1:0]       ready_vec;
    logic [1:0]       valid_vec;
    logic [1:0]       load_vec;
    logic [1:0]       drain_vec;
    logic [WIDTH-1:0] data_vec [2];
    logic [CNT_W-1:0] cnt_vec  [2];
    logic             in_xfer;

    assign ready_vec = {OUT1_READY, OUT0_READY};

    // The selected slot can take a word if empty, or if it is being drained
    // this same cycle (replace-in-place keeps one word per cycle throughput)
    assign IN_READY = !valid_vec[SEL] || ready_vec[SEL];
    assign in_xfer  = IN_VALID && IN_READY;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            assign drain_vec[gi] = valid_vec[gi] && ready_vec[gi];
            assign load_vec[gi]  = in_xfer && (SEL == gi[0]);

            demux_slot #(
                .WIDTH (WIDTH)
            ) u_slot (
                .clock   (clock),
                .reset_n (reset_n),
                .load    (load_vec[gi]),
                .drain   (drain_vec[gi]),
                .din     (D),
                .data    (data_vec[gi]),
                .valid   (valid_vec[gi]),
                .cnt     (cnt_vec[gi])
            );
        end
    endgenerate

    assign OUT0       = data_vec[0];
    assign OUT1       = data_vec[1];
    assign OUT0_VALID = valid_vec[0];
    assign OUT1_VALID = valid_vec[1];
    assign CNT0       = cnt_vec[0];
    assign CNT1       = cnt_vec[1];

endmodule : demux_1x2_reg

// File: tb/tb_demux_1x2_reg.sv
// Self-checking bench for demux_1x2_reg: directed cases plus randomized
// traffic compared against a per-channel queue scoreboard.
// Honours DEMUX_CNT_EN to decide whether the counters are expected to count.
module tb_demux_1x2_reg;

    localparam int WIDTH = 4;

    logic             clock = 1'b0;
    logic             reset_n;
    logic [WIDTH-1:0] D;
    logic             SEL;
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] OUT0;
    logic             OUT0_VALID;
    logic             OUT0_READY;
    logic [WIDTH-1:0] OUT1;
    logic             OUT1_VALID;
    logic             OUT1_READY;
    logic [7:0]       CNT0;
    logic [7:0]       CNT1;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference model: each channel is a queue of words awaiting consumption
    // (capacity one) plus a running count of words consumed since reset.
    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];
    int               consumed0;
    int               consumed1;

    demux_1x2_reg #(.WIDTH(WIDTH)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .D          (D),
        .SEL        (SEL),
        .IN_VALID   (IN_VALID),
        .IN_READY   (IN_READY),
        .OUT0       (OUT0),
        .OUT0_VALID (OUT0_VALID),
        .OUT0_READY (OUT0_READY),
        .OUT1       (OUT1),
        .OUT1_VALID (OUT1_VALID),
        .OUT1_READY (OUT1_READY),
        .CNT0       (CNT0),
        .CNT1       (CNT1)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_cnt(input int consumed);
`ifdef DEMUX_CNT_EN
        return 8'(consumed % 256);
`else
        return 8'd0;
`endif
    endfunction

    // One clock cycle: drive inputs after the falling edge, check the DUT
    // against the model, then advance the model to what the next rising edge does.
    task automatic cycle(input logic [WIDTH-1:0] d, input logic sel, input logic iv,
                         input logic r0, input logic r1, input bit verbose);
        bit exp_ready;
        bit drain0, drain1;
        @(negedge clock);
        D = d; SEL = sel; IN_VALID = iv; OUT0_READY = r0; OUT1_READY = r1;
        #1;
        exp_ready = sel ? ((q1.size() == 0) || r1) : ((q0.size() == 0) || r0);
        check("in_ready", 32'(IN_READY), 32'(exp_ready));
        check("out0_valid", 32'(OUT0_VALID), 32'(q0.size() != 0));
        check("out1_valid", 32'(OUT1_VALID), 32'(q1.size() != 0));
        if (q0.size() != 0) check("out0_data", 32'(OUT0), 32'(q0[0]));
        if (q1.size() != 0) check("out1_data", 32'(OUT1), 32'(q1[0]));
        check("cnt0", 32'(CNT0), 32'(exp_cnt(consumed0)));
        check("cnt1", 32'(CNT1), 32'(exp_cnt(consumed1)));
        drain0 = (q0.size() != 0) && r0;
        drain1 = (q1.size() != 0) && r1;
        if (drain0) begin void'(q0.pop_front()); consumed0++; end
        if (drain1) begin void'(q1.pop_front()); consumed1++; end
        if (iv && exp_ready) begin
            if (sel) q1.push_back(d); else q0.push_back(d);
        end
        if (verbose)
            $display("cyc d=%h sel=%0d iv=%0d r0=%0d r1=%0d | rdy=%0d v0=%0d o0=%h v1=%0d o1=%h c0=%0d c1=%0d",
                     d, sel, iv, r0, r1, IN_READY, OUT0_VALID, OUT0, OUT1_VALID, OUT1, CNT0, CNT1);
    endtask

    // Assert reset between clock edges and check outputs clear immediately
    task automatic apply_reset();
        @(negedge clock);
        IN_VALID = 1'b0; OUT0_READY = 1'b0; OUT1_READY = 1'b0; SEL = 1'b0; D = '0;
        #2 reset_n = 1'b0;
        #1;
        check("rst_out0", 32'(OUT0), 32'h0);
        check("rst_out1", 32'(OUT1), 32'h0);
        check("rst_v0", 32'(OUT0_VALID), 32'h0);
        check("rst_v1", 32'(OUT1_VALID), 32'h0);
        check("rst_cnt0", 32'(CNT0), 32'h0);
        check("rst_cnt1", 32'(CNT1), 32'h0);
        check("rst_in_ready", 32'(IN_READY), 32'h1);
        $display("reset asserted mid-cycle at %0t", $time);
        q0.delete(); q1.delete();
        consumed0 = 0; consumed1 = 0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        D = '0; SEL = 1'b0; IN_VALID = 1'b0; OUT0_READY = 1'b0; OUT1_READY = 1'b0;
        q0.delete(); q1.delete();
        consumed0 = 0; consumed1 = 0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        // Load channel 1 and leave it stalled, then reset mid-handshake
        cycle(4'h7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle(4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t1_v1_before_rst", 32'(OUT1_VALID), 32'h1);
        apply_reset();

        // Channel 0 load with consumer stalled; second word to ch0 refused
        cycle(4'hA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle(4'h3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        check("t2_in_ready_low", 32'(IN_READY), 32'h0);
        check("t2_out0_held", 32'(OUT0), 32'hA);
        check("t2_v1_low", 32'(OUT1_VALID), 32'h0);

        // Replace-in-place: ch0 full, consumer ready, new word to ch0
        cycle(4'h5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        check("t3_in_ready", 32'(IN_READY), 32'h1);
        cycle(4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t3_out0_new", 32'(OUT0), 32'h5);
        check("t3_v0", 32'(OUT0_VALID), 32'h1);

        // Ch0 stalled, load to ch1 accepted, ch0 untouched
        cycle(4'h7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        check("t4_in_ready", 32'(IN_READY), 32'h1);
        cycle(4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t4_out1", 32'(OUT1), 32'h7);
        check("t4_out0_kept", 32'(OUT0), 32'h5);

        // Exactly 256 drains on channel 1 since reset: counter wraps to 0
        apply_reset();
        for (int i = 0; i < 256; i++)
            cycle(4'(i), 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        cycle(4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        cycle(4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t5_cnt1_wrapped", 32'(CNT1), 32'h0);
        check("t5_v1_empty", 32'(OUT1_VALID), 32'h0);

        // Randomized traffic against the scoreboard
        for (int i = 0; i < 10000; i++)
            cycle(4'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0), 1'b0);
        $display("random phase: ch0 consumed %0d, ch1 consumed %0d", consumed0, consumed1);

        // Drain both channels and confirm nothing left behind
        cycle(4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        cycle(4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        check("final_v0", 32'(OUT0_VALID), 32'h0);
        check("final_v1", 32'(OUT1_VALID), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule : tb_demux_1x2_reg
